// File: rtl/event_packet_decoder.sv
// event_packet_decoder
//   Frames the raw uart_rx byte stream into 4-byte checksummed event packets
//   ({0,x}, {0,y}, {7'b0,pol}, xor of the first three), buffers good events in
//   a small FIFO and presents them on a valid/ready interface. Also decodes the
//   0xFF ping byte and reports dropped packets.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   rx_data, rx_valid    - byte stream from uart_rx (one-cycle strobe)
//   ev_valid, ev_ready   - event handshake (FIFO head)
//   ev_x, ev_y, ev_pol   - head event fields (combinational FIFO read)
//   ping                 - one-cycle pulse per ping byte
//   err_chk/tmo/ovf      - one-cycle pulses: checksum, timeout, FIFO overflow
//   drop_count           - saturating count of dropped packets
module event_packet_decoder #(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned TIMEOUT_CLKS = 2080
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [6:0] ev_x,
   output logic [6:0] ev_y,
   output logic       ev_pol,
   output logic       ping,
   output logic       err_chk,
   output logic       err_tmo,
   output logic       err_ovf,
   output logic [7:0] drop_count
);

   localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW       = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT_CLKS - 1);

   typedef enum logic [1:0] {S_B0, S_B1, S_B2, S_B3} state_t;

   state_t        state_q;
   logic [6:0]    x_q, y_q;
   logic          pol_q;
   logic [7:0]    xor_q;
   logic [15:0]   tmo_q;
   logic          ping_q, err_chk_q, err_tmo_q, err_ovf_q;
   logic [7:0]    drop_q;

   logic [14:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   logic full, pop, tmo_expire, pkt_done, chk_match;
   logic push_d, ovf_d, chk_err_d, drop_d;

   always_comb begin
      full       = (count_q == DEPTH_C);
      pop        = (count_q != '0) && ev_ready;
      // Expiry only without a byte this cycle: a byte on the expiry cycle wins.
      tmo_expire = (state_q != S_B0) && !rx_valid && (tmo_q == TMO_LAST);
      pkt_done   = (state_q == S_B3) && rx_valid;
      chk_match  = (rx_data == xor_q);
      // A full FIFO still takes the write when the head pops the same cycle.
      push_d     = pkt_done && chk_match && (!full || pop);
      ovf_d      = pkt_done && chk_match && full && !pop;
      chk_err_d  = pkt_done && !chk_match;
      drop_d     = ovf_d || chk_err_d || tmo_expire;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_B0;
         x_q       <= '0;
         y_q       <= '0;
         pol_q     <= 1'b0;
         xor_q     <= '0;
         tmo_q     <= '0;
         ping_q    <= 1'b0;
         err_chk_q <= 1'b0;
         err_tmo_q <= 1'b0;
         err_ovf_q <= 1'b0;
         drop_q    <= '0;
      end else begin
         ping_q    <= 1'b0;
         err_chk_q <= 1'b0;
         err_tmo_q <= 1'b0;
         err_ovf_q <= 1'b0;

         if (rx_valid || state_q == S_B0 || tmo_expire) tmo_q <= '0;
         else                                           tmo_q <= tmo_q + 16'd1;

         if (tmo_expire) begin
            err_tmo_q <= 1'b1;
            state_q   <= S_B0;
         end else if (rx_valid) begin
            unique case (state_q)
               S_B0: begin
                  if (rx_data == 8'hFF) begin
                     ping_q <= 1'b1;
                  end else if (!rx_data[7]) begin
                     x_q     <= rx_data[6:0];
                     xor_q   <= rx_data;   // loading B0 doubles as the S0 clear
                     state_q <= S_B1;
                  end
               end
               S_B1: begin
                  y_q     <= rx_data[6:0];
                  xor_q   <= xor_q ^ rx_data;
                  state_q <= S_B2;
               end
               S_B2: begin
                  pol_q   <= rx_data[0];
                  xor_q   <= xor_q ^ rx_data;
                  state_q <= S_B3;
               end
               S_B3: begin
                  err_chk_q <= chk_err_d;
                  err_ovf_q <= ovf_d;
                  state_q   <= S_B0;
               end
               default: state_q <= S_B0;
            endcase
         end

         if (drop_d && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_d) begin
            mem_q[wr_ptr_q] <= {x_q, y_q, pol_q};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_d && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push_d) count_q <= count_q - 1'b1;
      end
   end

   assign ev_valid   = (count_q != '0);
   assign ev_x       = mem_q[rd_ptr_q][14:8];
   assign ev_y       = mem_q[rd_ptr_q][7:1];
   assign ev_pol     = mem_q[rd_ptr_q][0];
   assign ping       = ping_q;
   assign err_chk    = err_chk_q;
   assign err_tmo    = err_tmo_q;
   assign err_ovf    = err_ovf_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_event_packet_decoder.sv
// tb_event_packet_decoder
//   Directed bench for event_packet_decoder with default parameters.
//   Table of whole packets plus hand-written timeout, ping/resync, overflow,
//   saturation and reset sequences.
module tb_event_packet_decoder;

   localparam int unsigned TMO = 2080;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       ev_valid;
   logic       ev_ready;
   logic [6:0] ev_x, ev_y;
   logic       ev_pol;
   logic       ping, err_chk, err_tmo, err_ovf;
   logic [7:0] drop_count;

   event_packet_decoder #(.FIFO_DEPTH(8), .TIMEOUT_CLKS(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_x       (ev_x),
      .ev_y       (ev_y),
      .ev_pol     (ev_pol),
      .ping       (ping),
      .err_chk    (err_chk),
      .err_tmo    (err_tmo),
      .err_ovf    (err_ovf),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b0, b1, b2, b3;
      logic       ok;
      logic [6:0] x, y;
      logic       pol;
   } vec_t;

   vec_t vecs[7];
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_drop = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic send_pkt(input logic [7:0] b0, b1, b2, b3);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      send_byte(b3);
   endtask

   task automatic check_head(input string nm, input logic [6:0] x, y, input logic pol);
      check({nm, " ev_valid"}, int'(ev_valid), 1);
      check({nm, " ev_x"}, int'(ev_x), int'(x));
      check({nm, " ev_y"}, int'(ev_y), int'(y));
      check({nm, " ev_pol"}, int'(ev_pol), int'(pol));
   endtask

   function automatic logic [7:0] ovf_b3(input int i);
      logic [7:0] x8, y8;
      x8 = 8'(i);
      y8 = 8'(i + 16);
      return x8 ^ y8 ^ {7'b0, x8[0]};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{b0: 8'h12, b1: 8'h34, b2: 8'h01, b3: 8'h27, ok: 1'b1, x: 7'h12, y: 7'h34, pol: 1'b1};
      vecs[1] = '{b0: 8'h12, b1: 8'h34, b2: 8'h01, b3: 8'h26, ok: 1'b0, x: 7'h00, y: 7'h00, pol: 1'b0};
      vecs[2] = '{b0: 8'h12, b1: 8'h34, b2: 8'h01, b3: 8'h27, ok: 1'b1, x: 7'h12, y: 7'h34, pol: 1'b1};
      vecs[3] = '{b0: 8'h01, b1: 8'hFF, b2: 8'h00, b3: 8'hFE, ok: 1'b1, x: 7'h01, y: 7'h7F, pol: 1'b0};
      vecs[4] = '{b0: 8'h7F, b1: 8'h00, b2: 8'h00, b3: 8'h7F, ok: 1'b1, x: 7'h7F, y: 7'h00, pol: 1'b0};
      vecs[5] = '{b0: 8'h00, b1: 8'h00, b2: 8'hFE, b3: 8'hFE, ok: 1'b1, x: 7'h00, y: 7'h00, pol: 1'b0};
      vecs[6] = '{b0: 8'h55, b1: 8'h2A, b2: 8'h03, b3: 8'h7C, ok: 1'b1, x: 7'h55, y: 7'h2A, pol: 1'b1};

      rst      = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      ev_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // reset state
      check("rst ev_valid", int'(ev_valid), 0);
      check("rst ev_x", int'(ev_x), 0);
      check("rst ev_y", int'(ev_y), 0);
      check("rst ev_pol", int'(ev_pol), 0);
      check("rst pulses", int'({ping, err_chk, err_tmo, err_ovf}), 0);
      check("rst drop_count", int'(drop_count), 0);

      // table of whole packets, consumer always ready
      foreach (vecs[i]) begin
         send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
         if (!vecs[i].ok) exp_drop++;
         check($sformatf("vec%0d ev_valid", i), int'(ev_valid), int'(vecs[i].ok));
         if (vecs[i].ok) check_head($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].pol);
         check($sformatf("vec%0d err_chk", i), int'(err_chk), int'(!vecs[i].ok));
         check($sformatf("vec%0d tmo/ovf", i), int'({err_tmo, err_ovf}), 0);
         check($sformatf("vec%0d drop", i), int'(drop_count), exp_drop);
         tick();
         check($sformatf("vec%0d ev_valid after", i), int'(ev_valid), 0);
         check($sformatf("vec%0d err_chk after", i), int'(err_chk), 0);
      end

      // ping and resync in S0
      send_byte(8'hFF);
      check("ping pulse", int'(ping), 1);
      check("ping no err", int'({err_chk, err_tmo, err_ovf, ev_valid}), 0);
      tick();
      check("ping one cycle", int'(ping), 0);
      send_byte(8'h80);
      check("resync no ping", int'(ping), 0);
      check("resync no err", int'({err_chk, err_tmo, err_ovf, ev_valid}), 0);
      send_pkt(8'h03, 8'h04, 8'h01, 8'h06);
      check_head("after resync", 7'h03, 7'h04, 1'b1);
      check("after resync drop", int'(drop_count), exp_drop);
      tick();

      // inter-byte timeout
      send_byte(8'h05);
      send_byte(8'h06);
      repeat (TMO - 1) tick();
      check("tmo not early", int'(err_tmo), 0);
      tick();
      exp_drop++;
      check("tmo pulse", int'(err_tmo), 1);
      check("tmo drop", int'(drop_count), exp_drop);
      tick();
      check("tmo one cycle", int'(err_tmo), 0);
      send_pkt(8'h07, 8'h08, 8'h00, 8'h0F);
      check_head("post tmo", 7'h07, 7'h08, 1'b0);
      check("post tmo err_chk", int'(err_chk), 0);
      tick();

      // byte exactly on the expiry cycle wins
      send_byte(8'h05);
      send_byte(8'h06);
      repeat (TMO - 1) tick();
      send_byte(8'h00);
      check("tmo boundary no pulse", int'(err_tmo), 0);
      send_byte(8'h03);
      check_head("tmo boundary pkt", 7'h05, 7'h06, 1'b0);
      check("tmo boundary drop", int'(drop_count), exp_drop);
      tick();

      // overflow with consumer stalled
      ev_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         send_pkt(8'(i), 8'(i + 16), {7'b0, 1'(i)}, ovf_b3(i));
         check($sformatf("ovf pkt%0d err_ovf", i), int'(err_ovf), (i > 8) ? 1 : 0);
         if (i > 8) exp_drop++;
      end
      check("ovf drop", int'(drop_count), exp_drop);
      check_head("ovf head", 7'd1, 7'd17, 1'b1);
      // full FIFO + pop on the B3 cycle: write accepted
      send_byte(8'd11);
      send_byte(8'd27);
      send_byte(8'h01);
      ev_ready = 1'b1;
      send_byte(ovf_b3(11));
      check("full+pop no ovf", int'(err_ovf), 0);
      check("full+pop drop", int'(drop_count), exp_drop);
      for (int i = 2; i <= 9; i++) begin
         automatic int k = (i == 9) ? 11 : i;
         check_head($sformatf("drain%0d", k), 7'(k), 7'(k + 16), 1'(k));
         tick();
      end
      check("drain empty", int'(ev_valid), 0);

      // saturation
      for (int i = 0; i < 300; i++) send_pkt(8'h01, 8'h02, 8'h03, 8'h01);
      check("sat err_chk", int'(err_chk), 1);
      check("sat drop", int'(drop_count), 255);
      tick();

      // reset mid-packet with FIFO non-empty
      ev_ready = 1'b0;
      send_pkt(8'h12, 8'h34, 8'h01, 8'h27);
      check("pre-rst ev_valid", int'(ev_valid), 1);
      send_byte(8'h0A);
      send_byte(8'h0B);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid rst ev_valid", int'(ev_valid), 0);
      check("mid rst ev_x", int'(ev_x), 0);
      check("mid rst ev_y", int'(ev_y), 0);
      check("mid rst ev_pol", int'(ev_pol), 0);
      check("mid rst pulses", int'({ping, err_chk, err_tmo, err_ovf}), 0);
      check("mid rst drop", int'(drop_count), 0);
      ev_ready = 1'b1;
      send_pkt(8'h07, 8'h08, 8'h00, 8'h0F);
      check_head("post rst pkt", 7'h07, 7'h08, 1'b0);
      check("post rst drop", int'(drop_count), 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
